fir_ctrl: RTL and testbench

Sequencing controller for the 8-tap systolic FIR processing-element chain. It holds the coefficient bank that drives every PE's coefficient input and accepts input samples over a valid/ready handshake. It streams those samples into the chain's X input and drains the pipeline at end of frame. A tag pipeline marks which chain outputs correspond to real samples, and those outputs are presented with valid/last qualifiers.

---
 rtl/fir_ctrl.sv | 136 +++++++++++++
 tb/tb_fir_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_ctrl.sv
// Sequencing controller for an 8-tap systolic FIR chain: coefficient bank, sample
// handshake, end-of-frame flush, tagged outputs. FIR_CTRL_SYM_COEF_EN mirrors coef writes.
module fir_ctrl_tap #(
  parameter int IDX  = 0,
  parameter int TAPS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] data,
  output logic [7:0] coef
);
  localparam logic [2:0] SELF = 3'(IDX);
  logic hit;
`ifdef FIR_CTRL_SYM_COEF_EN
  localparam logic [2:0] MIRR = 3'(TAPS - 1 - IDX);
  assign hit = we && (addr == SELF || addr == MIRR);
`else
  assign hit = we && (addr == SELF);
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   coef <= '0;
    else if (hit) coef <= data;
endmodule

module fir_ctrl #(
  parameter int TAPS     = 8,
  parameter int PIPE_LAT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  input  logic                coef_we,
  input  logic [2:0]          coef_addr,
  input  logic [7:0]          coef_data,
  output logic                coef_err,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_data,
  input  logic                in_last,
  output logic [7:0]          pe_xin,
  output logic [8*TAPS-1:0]   pe_cin,
  output logic [15:0]         pe_yin,
  input  logic [15:0]         pe_yout,
  output logic                out_valid,
  output logic [15:0]         out_data,
  output logic                out_last
);
  localparam int CW = $clog2(PIPE_LAT + 2);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t         state, state_nxt;
  logic [CW-1:0]  flush_cnt, flush_cnt_nxt;
  logic           acc, done_nxt, coef_wr, addr_ok;
  logic [PIPE_LAT:0] vld_pipe, lst_pipe;

  assign busy    = (state != IDLE);
  assign pe_yin  = '0;
  assign addr_ok = ({29'b0, coef_addr} < 32'(TAPS));
  assign coef_wr = coef_we && (state == IDLE);

  for (genvar g = 0; g < TAPS; g++) begin : g_tap
    fir_ctrl_tap #(.IDX(g), .TAPS(TAPS)) u_tap (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (coef_wr),
      .addr (coef_addr),
      .data (coef_data),
      .coef (pe_cin[8*g +: 8])
    );
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    done_nxt      = 1'b0;
    in_ready      = 1'b0;
    acc           = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        in_ready = 1'b1;
        acc      = in_valid;
        if (in_valid && in_last) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = CW'(PIPE_LAT);
        end
      end
      FLUSH: begin
        // counts PIPE_LAT..0, so the drain spans PIPE_LAT+1 cycles
        if (flush_cnt == '0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          flush_cnt_nxt = flush_cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bubbles still push a zero into the chain; only the tag marks them invalid.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pe_xin    <= '0;
      vld_pipe  <= '0;
      lst_pipe  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
      coef_err  <= 1'b0;
    end else begin
      pe_xin    <= acc ? in_data : 8'd0;
      vld_pipe  <= {vld_pipe[PIPE_LAT-1:0], acc};
      lst_pipe  <= {lst_pipe[PIPE_LAT-1:0], acc & in_last};
      out_valid <= vld_pipe[PIPE_LAT];
      out_last  <= lst_pipe[PIPE_LAT];
      out_data  <= pe_yout;
      done      <= done_nxt;
      coef_err  <= coef_we && (state != IDLE) && addr_ok;
    end
endmodule

// File: tb/tb_fir_ctrl.sv
// Scoreboard bench for fir_ctrl: a behavioural chain fixture drives pe_yout, a
// frame-level FIR reference fills the expected queue, a monitor checks outputs.
module tb_fir_ctrl;
  localparam int TAPS     = 8;
  localparam int PIPE_LAT = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0, busy, done;
  logic                coef_we = 1'b0, coef_err;
  logic [2:0]          coef_addr = '0;
  logic [7:0]          coef_data = '0;
  logic                in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [7:0]          in_data = '0, pe_xin;
  logic [8*TAPS-1:0]   pe_cin;
  logic [15:0]         pe_yin, pe_yout, out_data;
  logic                out_valid, out_last;

  fir_ctrl #(.TAPS(TAPS), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .pe_xin(pe_xin), .pe_cin(pe_cin), .pe_yin(pe_yin), .pe_yout(pe_yout),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Chain fixture: y = sum c[k]*x[n-k], visible PIPE_LAT edges after x hits pe_xin.
  logic [7:0]  xh [TAPS-1] = '{default: 8'd0};
  logic [15:0] dl [PIPE_LAT] = '{default: 16'd0};
  assign pe_yout = dl[PIPE_LAT-1];
  always @(posedge clk) begin
    logic [15:0] y;
    y = 16'(pe_xin) * 16'(pe_cin[7:0]);
    for (int k = 1; k < TAPS; k++) y += 16'(xh[k-1]) * 16'(pe_cin[8*k +: 8]);
    dl[0] <= y;
    for (int k = 1; k < PIPE_LAT; k++) dl[k] <= dl[k-1];
    xh[0] <= pe_xin;
    for (int k = 1; k < TAPS-1; k++) xh[k] <= xh[k-1];
  end

  typedef struct { logic [15:0] d; logic l; } exp_t;
  exp_t sb[$];
  int   mc[TAPS];
  int   fr[$];
  int   n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [8*TAPS-1:0] pack_coef();
    logic [8*TAPS-1:0] v;
    for (int k = 0; k < TAPS; k++) v[8*k +: 8] = 8'(mc[k]);
    return v;
  endfunction

  function automatic logic [15:0] fir_ref(input int xs[$]);
    int acc = 0;
    int n = xs.size() - 1;
    for (int k = 0; k < TAPS && k <= n; k++) acc += mc[k] * xs[n-k];
    return 16'(acc);
  endfunction

  function automatic void model_wr(input int a, input int d);
    mc[a] = d;
`ifdef FIR_CTRL_SYM_COEF_EN
    mc[TAPS-1-a] = d;
`endif
  endfunction

  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_unexpected: out_data %0d arrived with nothing expected", out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", 64'(out_data), 64'(e.d));
        chk("out_last", 64'(out_last), 64'(e.l));
      end
    end
  end

  task automatic wr_coef(input int a, input int d);
    coef_we = 1'b1; coef_addr = 3'(a); coef_data = 8'(d);
    model_wr(a, d);
    @(negedge clk);
    coef_we = 1'b0;
    chk("coef_err_idle", 64'(coef_err), 64'd0);
    chk("pe_cin", 64'(pe_cin), 64'(pack_coef()));
  endtask

  // Plays fr[] (-1 = bubble, last entry carries in_last) through one frame.
  task automatic do_frame(input int wr_at, input bit st_wr);
    int xs[$];
    int cyc, last_i;
    last_i = fr.size() - 1;
    xs.delete();
    start = 1'b1;
    if (st_wr) begin
      coef_we = 1'b1; coef_addr = 3'd0; coef_data = 8'd5;
      model_wr(0, 5);
    end
    @(negedge clk);
    start = 1'b0; coef_we = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    for (int i = 0; i <= last_i; i++) begin
      chk("in_ready_run", 64'(in_ready), 64'd1);
      in_valid = (fr[i] >= 0);
      in_data  = (fr[i] >= 0) ? 8'(fr[i]) : 8'($urandom_range(0, 255));
      in_last  = (i == last_i) ? 1'b1 : (fr[i] < 0 ? 1'($urandom_range(0, 1)) : 1'b0);
      start    = (i != last_i) && ($urandom_range(0, 3) == 0);
      if (i == wr_at) begin
        coef_we = 1'b1; coef_addr = 3'd2; coef_data = 8'd9;
      end
      xs.push_back(fr[i] >= 0 ? fr[i] : 0);
      if (fr[i] >= 0) sb.push_back('{d: fir_ref(xs), l: (i == last_i)});
      @(negedge clk);
      coef_we = 1'b0;
      chk("pe_xin", 64'(pe_xin), 64'(xs[xs.size()-1]));
      if (i == wr_at) begin
        chk("coef_err_busy", 64'(coef_err), 64'd1);
        chk("pe_cin_tap2_kept", 64'(pe_cin[23:16]), 64'(mc[2]));
      end
      if (i == wr_at + 1) chk("coef_err_pulse_end", 64'(coef_err), 64'd0);
    end
    in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      chk("in_ready_flush", 64'(in_ready), 64'd0);
      chk("done_low_flush", 64'(done), 64'd0);
      cyc++;
      @(negedge clk);
    end
    chk("flush_len", 64'(cyc), 64'(PIPE_LAT + 1));
    chk("done_pulse", 64'(done), 64'd1);
    @(negedge clk);
    chk("done_single", 64'(done), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < TAPS; k++) mc[k] = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_coef_err", 64'(coef_err), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_pe_xin", 64'(pe_xin), 64'd0);
    chk("rst_pe_cin", 64'(pe_cin), 64'd0);
    chk("rst_pe_yin", 64'(pe_yin), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // impulse response
    for (int a = 0; a < TAPS; a++) wr_coef(a, a + 1);
    fr = '{1, 0, 0, 0, 0, 0, 0, 0};
    do_frame(-1, 1'b0);

    // bubbles: 2, gap, 3 -> 2 and 5
    for (int a = 0; a < TAPS; a++) wr_coef(a, 1);
    fr = '{2, -1, 3};
    do_frame(-1, 1'b0);

    // coefficient write attempted while running
    fr = '{4, 9, -1, 17, 1, 200};
    do_frame(2, 1'b0);

    // start and coef write on the same edge
    for (int a = 0; a < TAPS; a++) wr_coef(a, 0);
    fr = '{1};
    do_frame(-1, 1'b1);

    // single sample flush: 7 * 3 = 21
    for (int a = 0; a < TAPS; a++) wr_coef(a, 0);
    wr_coef(0, 3);
    fr = '{7};
    do_frame(-1, 1'b0);

    wr_coef(1, 4);
    chk("tap1", 64'(pe_cin[15:8]), 64'd4);
`ifdef FIR_CTRL_SYM_COEF_EN
    chk("sym_tap6", 64'(pe_cin[55:48]), 64'd4);
`endif

    // reset in the middle of a frame
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      in_valid = 1'b1; in_data = 8'($urandom_range(1, 255));
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_pe_cin", 64'(pe_cin), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_pe_xin", 64'(pe_xin), 64'd0);
    sb.delete();
    for (int k = 0; k < TAPS; k++) mc[k] = 0;
    repeat (2) begin
      @(negedge clk);
      chk("midrst_done", 64'(done), 64'd0);
      chk("midrst_hold_busy", 64'(busy), 64'd0);
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("postrst_done", 64'(done), 64'd0);
    end

    // randomized frames
    for (int f = 0; f < 5; f++) begin
      int len;
      for (int a = 0; a < TAPS; a++) wr_coef(a, int'($urandom_range(0, 255)));
      len = int'($urandom_range(5, 20));
      fr.delete();
      for (int i = 0; i < len - 1; i++)
        fr.push_back(($urandom_range(0, 9) < 3) ? -1 : int'($urandom_range(0, 255)));
      fr.push_back(int'($urandom_range(0, 255)));
      do_frame((f == 1) ? 1 : -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
